ex_mem_buf: RTL and testbench
=============================

// Module: ex_mem_buf
// PURPOSE
//   Pipeline boundary between the execute stage and the memory-access stage.
//   - Captures the execute result triple {write address, write enable, write data}.
//   - Presents it to the memory stage through a valid/ready handshake.
//   - Two-entry skid buffer, so a downstream stall never drops an in-flight result.
//   - The ready path is fully registered; no combinational ready loop back into execute.
// PARAMETERS
//   DATA_W  32  width of the result word (register-file data width)
//   ADDR_W  5   width of the destination register address
// PORTS
//   clk         in   1       single clock; all state updates on rising edge
//   rst         in   1       asynchronous, active-low reset
//   flush       in   1       synchronous pipeline flush; discards all held entries
//   ex_valid    in   1       execute stage presents a result this cycle
//   ex_ready    out  1       buffer accepts a result this cycle (registered)
//   ex_wd       in   ADDR_W  destination register address from execute
//   ex_wreg     in   1       register write enable from execute
//   ex_wdata    in   DATA_W  result data from execute
//   mem_valid   out  1       head entry valid toward memory stage
//   mem_ready   in   1       memory stage consumes head entry this cycle
//   mem_wd      out  ADDR_W  head entry destination address
//   mem_wreg    out  1       head entry write enable
//   mem_wdata   out  DATA_W  head entry data
// BEHAVIOUR
//   - Storage: head register H (drives mem_*) and skid register S. State is one of:
//     EMPTY, ONE (H valid), FULL (H and S valid).
//   - Handshake events:
//     - accept = ex_valid & ex_ready
//     - consume = mem_valid & mem_ready
//     - A transfer occurs only on the edge where the relevant pair is high.
//   - Transitions (no flush):
//     - EMPTY: accept -> load H, go ONE.
//     - ONE:
//       - accept & consume -> load H with new entry, stay ONE.
//       - accept only -> load S, go FULL.
//       - consume only -> go EMPTY.
//     - FULL:
//       - ex_ready=0, so no accept is possible.
//       - consume -> H <= S, go ONE.
//   - ex_ready = (state != FULL), taken from the state register. 0 during reset.
//   - Ordering: strict FIFO. An entry in S is never presented before H.
//   - Latency: a result accepted at edge N appears on mem_* after edge N when the buffer was
//     EMPTY or H was consumed at N. Otherwise it appears after the edge where H is consumed.
//   - Bubbles: when mem_valid=0, mem_wreg is forced to 0, and mem_wd and mem_wdata read 0.
//   - Flush: on the next edge, go EMPTY and drop H and S, including any accept on that same
//     edge. Flush has priority over every other event.
//   - Reset: asynchronous assertion returns state to EMPTY immediately, mid-transfer or not.
//     During reset:
//     - mem_valid = 0, mem_wreg = 0
//     - mem_wd = 0, mem_wdata = 0
//     - ex_ready = 0
//     Deassertion is sampled on clk; ex_ready rises 1 cycle after deassertion.
//   - ex_* fields are don't-care when ex_valid=0. The buffer must not capture them.
//   - Data paths are pass-through only; no arithmetic, no width conversion.
// CONFIGURATION
//   EX_MEM_FWD_EN: when defined, adds forwarding outputs toward decode to resolve RAW hazards:
//     - fwd_we    out  1       = mem_valid & mem_wreg
//     - fwd_wd    out  ADDR_W  = mem_wd
//     - fwd_wdata out  DATA_W  = mem_wdata
//     - fwd_s_we  out  1       = S valid & S.wreg
//     - fwd_s_wd  out  ADDR_W  = S.wd
//     - fwd_s_wdata out DATA_W = S.wdata
//     All are combinational from held state; zero during reset and when the entry is invalid.
//   When undefined: these ports do not exist and no logic is generated.
// TESTING
//   - Reset: rst=0 mid-FULL -> mem_valid=0, ex_ready=0 immediately; ex_ready=1 one cycle
//     after rst=1.
//   - Streaming: mem_ready=1, ex_valid=1 each cycle, wdata=1,2,3 ->
//     mem_wdata=1,2,3 on consecutive cycles; ex_ready stays 1.
//   - Stall: mem_ready=0, push wd=5/wdata=0xAAAA0000 then wd=6/wdata=0x0000BBBB ->
//     ex_ready=0 after the 2nd accept; release mem_ready -> 0xAAAA0000 then 0x0000BBBB, no loss.
//   - Flush: FULL and flush=1 with ex_valid=1 -> next cycle mem_valid=0, mem_wreg=0,
//     ex_ready=1; the flushed entries never appear.
//   - Bubble: ex_valid=0 with ex_wreg=1, ex_wd=31 -> mem_valid=0, mem_wreg=0, state unchanged.
//   - With EX_MEM_FWD_EN: FULL holding wd=3 (H) and wd=4 (S) ->
//     fwd_we=1, fwd_wd=3, fwd_s_we=1, fwd_s_wd=4.

Source files
------------

// File: rtl/ex_mem_buf.sv
// Execute-to-memory pipeline boundary: two-entry skid buffer with a registered ready.
// Optional forwarding outputs toward decode are built when EX_MEM_FWD_EN is defined.
module ex_mem_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_wd,
    input  logic              ex_wreg,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_wd,
    output logic              mem_wreg,
    output logic [DATA_W-1:0] mem_wdata
`ifdef EX_MEM_FWD_EN
    ,
    output logic              fwd_we,
    output logic [ADDR_W-1:0] fwd_wd,
    output logic [DATA_W-1:0] fwd_wdata,
    output logic              fwd_s_we,
    output logic [ADDR_W-1:0] fwd_s_wd,
    output logic [DATA_W-1:0] fwd_s_wdata
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_next;
    logic   ready_q;
    logic   accept, consume;
    logic   load_h, load_s, h_from_s;
    logic   h_vld, s_vld;

    logic [ADDR_W-1:0] h_wd, s_wd;
    logic              h_wreg, s_wreg;
    logic [DATA_W-1:0] h_wdata, s_wdata;

    assign h_vld    = (state != EMPTY);
    assign s_vld    = (state == FULL);
    assign ex_ready = ready_q;
    assign accept   = ex_valid & ready_q;
    assign consume  = h_vld & mem_ready;

    always_comb begin
        state_next = state;
        load_h     = 1'b0;
        load_s     = 1'b0;
        h_from_s   = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_h     = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_h = 1'b1;
                    end else if (accept) begin
                        load_s     = 1'b1;
                        state_next = FULL;
                    end else if (consume) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // ready is low here, so only a consume can move the buffer
                    if (consume) begin
                        h_from_s   = 1'b1;
                        state_next = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // ready is taken from the next state so it is a plain flop, low throughout reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (load_h) begin
            h_wd    <= ex_wd;
            h_wreg  <= ex_wreg;
            h_wdata <= ex_wdata;
        end else if (h_from_s) begin
            h_wd    <= s_wd;
            h_wreg  <= s_wreg;
            h_wdata <= s_wdata;
        end
        if (load_s) begin
            s_wd    <= ex_wd;
            s_wreg  <= ex_wreg;
            s_wdata <= ex_wdata;
        end
    end

    // Payload is masked by the valid bits so bubbles and reset always read zero
    assign mem_valid = h_vld;
    assign mem_wd    = h_vld ? h_wd : '0;
    assign mem_wreg  = h_vld & h_wreg;
    assign mem_wdata = h_vld ? h_wdata : '0;

`ifdef EX_MEM_FWD_EN
    assign fwd_we      = mem_wreg;
    assign fwd_wd      = mem_wd;
    assign fwd_wdata   = mem_wdata;
    assign fwd_s_we    = s_vld & s_wreg;
    assign fwd_s_wd    = s_vld ? s_wd : '0;
    assign fwd_s_wdata = s_vld ? s_wdata : '0;
`endif

endmodule

// File: tb/tb_ex_mem_buf.sv
// Bench for ex_mem_buf: directed stimulus, expected entries queued on accept and
// checked in order by an independent monitor on the falling edge.
module tb_ex_mem_buf;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              ex_valid = 1'b0;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_wd = '0;
    logic              ex_wreg = 1'b0;
    logic [DATA_W-1:0] ex_wdata = '0;
    logic              mem_valid;
    logic              mem_ready = 1'b0;
    logic [ADDR_W-1:0] mem_wd;
    logic              mem_wreg;
    logic [DATA_W-1:0] mem_wdata;
`ifdef EX_MEM_FWD_EN
    logic              fwd_we, fwd_s_we;
    logic [ADDR_W-1:0] fwd_wd, fwd_s_wd;
    logic [DATA_W-1:0] fwd_wdata, fwd_s_wdata;
`endif

    ex_mem_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata)
`ifdef EX_MEM_FWD_EN
        ,
        .fwd_we(fwd_we), .fwd_wd(fwd_wd), .fwd_wdata(fwd_wdata),
        .fwd_s_we(fwd_s_we), .fwd_s_wd(fwd_s_wd), .fwd_s_wdata(fwd_s_wdata)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+DATA_W:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: record what the DUT should accept on this edge, then settle past it
    task automatic step();
        logic acc;
        acc = ex_valid && ex_ready && !flush && rst;
        @(posedge clk);
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back({ex_wd, ex_wreg, ex_wdata});
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] wd, input logic wr,
                         input logic [DATA_W-1:0] wdat);
        ex_valid = v;
        ex_wd    = wd;
        ex_wreg  = wr;
        ex_wdata = wdat;
    endtask

    // Monitor: every consume must match the oldest accepted entry; bubbles must read zero
    initial begin
        logic [ADDR_W+DATA_W:0] exp;
        forever begin
            @(negedge clk);
            if (mem_valid && mem_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: got wd=%0d wdata=0x%0h expected no entry",
                             mem_wd, mem_wdata);
                end else begin
                    exp = exp_q.pop_front();
                    check("mon_entry", 64'({mem_wd, mem_wreg, mem_wdata}), 64'(exp));
                end
            end else if (!mem_valid) begin
                check("mon_bubble", 64'({mem_wd, mem_wreg, mem_wdata}), 64'(0));
            end
        end
    end

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(ex_ready), 64'(0));
        check("rst_valid", 64'(mem_valid), 64'(0));
        rst = 1'b1;
        check("rst_ready_deassert", 64'(ex_ready), 64'(0));
        step();
        check("rst_ready_rise", 64'(ex_ready), 64'(1));

        // Streaming
        mem_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, ADDR_W'(i), 1'b1, DATA_W'(i));
            check("stream_ready", 64'(ex_ready), 64'(1));
            step();
            check("stream_wdata", 64'(mem_wdata), 64'(i));
        end
        drive(1'b0, '0, 1'b0, '0);
        step();
        check("stream_drained", 64'(mem_valid), 64'(0));

        // Stall
        mem_ready = 1'b0;
        drive(1'b1, 5'd5, 1'b1, 32'hAAAA0000);
        step();
        check("stall_ready1", 64'(ex_ready), 64'(1));
        drive(1'b1, 5'd6, 1'b1, 32'h0000BBBB);
        step();
        check("stall_ready_full", 64'(ex_ready), 64'(0));
        drive(1'b1, 5'd7, 1'b1, 32'hDEADBEEF);
        step();
        check("stall_head", 64'(mem_wdata), 64'hAAAA0000);
        drive(1'b0, '0, 1'b0, '0);
        mem_ready = 1'b1;
        step();
        check("stall_second", 64'(mem_wdata), 64'h0000BBBB);
        check("stall_ready_back", 64'(ex_ready), 64'(1));
        step();
        check("stall_empty", 64'(mem_valid), 64'(0));

        // Flush while full, with a competing accept
        mem_ready = 1'b0;
        drive(1'b1, 5'd8, 1'b1, 32'h8888);
        step();
        drive(1'b1, 5'd9, 1'b1, 32'h9999);
        step();
        flush = 1'b1;
        drive(1'b1, 5'd10, 1'b1, 32'h1010);
        step();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        check("flush_valid", 64'(mem_valid), 64'(0));
        check("flush_wreg", 64'(mem_wreg), 64'(0));
        check("flush_ready", 64'(ex_ready), 64'(1));
        mem_ready = 1'b1;
        step();
        check("flush_gone", 64'(mem_valid), 64'(0));

        // Bubble: fields on an invalid cycle are ignored
        mem_ready = 1'b0;
        drive(1'b0, 5'd31, 1'b1, 32'hFFFF);
        step();
        check("bubble_valid", 64'(mem_valid), 64'(0));
        check("bubble_wreg", 64'(mem_wreg), 64'(0));
        check("bubble_ready", 64'(ex_ready), 64'(1));
        drive(1'b1, 5'd3, 1'b1, 32'h33);
        step();
        drive(1'b0, 5'd31, 1'b1, 32'hFFFF);
        step();
        check("bubble_hold_wd", 64'(mem_wd), 64'(3));
        check("bubble_hold_wdata", 64'(mem_wdata), 64'h33);

        // Fill to FULL with wd=3 in head and wd=4 in skid
        drive(1'b1, 5'd4, 1'b1, 32'h44);
        step();
        drive(1'b0, '0, 1'b0, '0);
        check("full_ready", 64'(ex_ready), 64'(0));
        check("full_head_wd", 64'(mem_wd), 64'(3));
`ifdef EX_MEM_FWD_EN
        check("fwd_we", 64'(fwd_we), 64'(1));
        check("fwd_wd", 64'(fwd_wd), 64'(3));
        check("fwd_s_we", 64'(fwd_s_we), 64'(1));
        check("fwd_s_wd", 64'(fwd_s_wd), 64'(4));
`endif

        // Asynchronous reset in the middle of a cycle while FULL
        rst = 1'b0;
        #1;
        exp_q.delete();
        check("arst_valid", 64'(mem_valid), 64'(0));
        check("arst_ready", 64'(ex_ready), 64'(0));
        check("arst_wd", 64'(mem_wd), 64'(0));
        #2;
        rst = 1'b1;
        check("arst_ready_hold", 64'(ex_ready), 64'(0));
        step();
        check("arst_ready_rise", 64'(ex_ready), 64'(1));
        check("arst_empty", 64'(mem_valid), 64'(0));

        // Final drain: every accepted entry must have been delivered
        mem_ready = 1'b1;
        repeat (3) step();
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
